// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86-64 data-memory stage.
//   dmem_state_t : responder FSM states
//   dmem_req_t   : latched memory request (operation, address, write data)
//   WORD_BYTES   : bytes per quad-word access
//   CNT_W        : latency counter width (covers LATENCY up to 15)
//   RMMOVQ..POPQ : icodes of the instructions that touch data memory
package y86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned CNT_W      = 4;

    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
    } dmem_req_t;

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with one 8-byte little-endian port.
//   clk         : write clock
//   wr_en_i     : commit wr_data_i to bytes addr_i..addr_i+7 at the rising edge
//   addr_i      : byte address of the quad-word
//   wr_data_i   : write data, byte 0 goes to addr_i
//   rd_data_c_o : combinational read of bytes addr_i..addr_i+7
module dmem_byte_array #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned AW        = 10
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wr_data_i,
    output logic [63:0]   rd_data_c_o
);

    logic [7:0] mem_q [MEM_BYTES];

    // Synchronous little-endian quad-word write.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[AW'(addr_i + AW'(k))] <= wr_data_i[8*k +: 8];
            end
        end
    end

    // Combinational little-endian quad-word read.
    always_comb begin
        rd_data_c_o = '0;
        for (int k = 0; k < 8; k++) begin
            rd_data_c_o[8*k +: 8] = mem_q[AW'(addr_i + AW'(k))];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency data-memory responder for the SEQ Y86-64 memory stage.
//   clk, reset                 : rising-edge clock, async active-high reset
//   read_enable, write_enable  : request strobes, sampled while not in flight
//   mem_address, mem_data      : quad-word byte address and write data
//   valM                       : read data, held until the next good read
//   mem_done                   : one-cycle completion pulse
//   dmem_error                 : status of the last completed request
//   busy                       : request in flight
module data_memory
    import y86_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               read_enable,
    input  logic               write_enable,
    input  logic signed [63:0] mem_address,
    input  logic signed [63:0] mem_data,
    output logic signed [63:0] valM,
    output logic               mem_done,
    output logic               dmem_error,
    output logic               busy
);

    localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic [63:0]      valm_q, valm_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [64:0]      end_addr_c;
    logic             req_err_c;
    logic             wr_en_c;
    logic [63:0]      rd_data_c;

    // 65-bit end address so a large positive address cannot wrap into range.
    assign end_addr_c = {1'b0, req_q.addr} + 65'(WORD_BYTES);
    assign req_err_c  = req_q.addr[63]
                      | (end_addr_c > 65'(MEM_BYTES))
                      | (req_q.rd & req_q.wr);

    dmem_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_array (
        .clk         (clk),
        .wr_en_i     (wr_en_c),
        .addr_i      (req_q.addr[AW-1:0]),
        .wr_data_i   (req_q.data),
        .rd_data_c_o (rd_data_c)
    );

    // Next-state and output logic. RESP is the mem_done cycle; a request
    // seen there is accepted immediately so back-to-back spacing is LATENCY+1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valm_d  = valm_q;
        err_d   = err_q;
        done_d  = 1'b0;
        wr_en_c = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (read_enable || write_enable) begin
                    req_d   = '{rd: read_enable, wr: write_enable,
                                addr: mem_address, data: mem_data};
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = req_err_c;
                    if (!req_err_c) begin
                        if (req_q.wr) begin
                            wr_en_c = 1'b1;
                        end else begin
                            valm_d = rd_data_c;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            valm_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valm_q  <= valm_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign valM       = valm_q;
    assign mem_done   = done_q;
    assign dmem_error = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    logic clk;
    logic reset0, reset1;
    logic rd0, wr0, rd1, wr1;
    logic signed [63:0] addr0, data0, addr1, data1;
    logic signed [63:0] valm0, valm1;
    logic done0, err0, busy0, done1, err1, busy1;

    int checks;
    int errors;

    logic [7:0]  mdl0 [1024];
    logic [7:0]  mdl1 [64];
    logic [63:0] mval0, mval1;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [63:0] a;
        logic [63:0] d;
        bit          ee;
        logic [63:0] ev;
    } vec_t;

    vec_t vecs [13];

    data_memory #(.MEM_BYTES(1024), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset0), .read_enable(rd0), .write_enable(wr0),
        .mem_address(addr0), .mem_data(data0), .valM(valm0),
        .mem_done(done0), .dmem_error(err0), .busy(busy0)
    );

    data_memory #(.MEM_BYTES(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset1), .read_enable(rd1), .write_enable(wr1),
        .mem_address(addr1), .mem_data(data1), .valM(valm1),
        .mem_done(done1), .dmem_error(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic s_done(input bit w); return w ? done1 : done0; endfunction
    function automatic logic s_err(input bit w);  return w ? err1 : err0;   endfunction
    function automatic logic s_busy(input bit w); return w ? busy1 : busy0; endfunction
    function automatic logic [63:0] s_val(input bit w); return w ? valm1 : valm0; endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, required 0x%h", nm, got, exp);
        end
    endtask

    task automatic drive(input bit w, input bit rd, input bit wr,
                         input logic [63:0] a, input logic [63:0] d);
        if (w) begin
            rd1 = rd; wr1 = wr; addr1 = a; data1 = d;
        end else begin
            rd0 = rd; wr0 = wr; addr0 = a; data0 = d;
        end
    endtask

    // Reference: byte-array semantics with range/conflict error rules.
    task automatic model_req(input bit w, input bit rd, input bit wr,
                             input logic [63:0] a, input logic [63:0] d, output bit e);
        int unsigned msz;
        logic [64:0] endp;
        msz  = w ? 64 : 1024;
        endp = {1'b0, a} + 65'd8;
        e = a[63] || (endp > 65'(msz)) || (rd && wr);
        if (!e) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = int'(a[9:0]) + k;
                if (wr) begin
                    if (w) mdl1[idx] = d[8*k +: 8];
                    else   mdl0[idx] = d[8*k +: 8];
                end else begin
                    if (w) mval1[8*k +: 8] = mdl1[idx];
                    else   mval0[8*k +: 8] = mdl0[idx];
                end
            end
        end
    endtask

    // One request pulsed for one cycle; observe completion on negedges.
    task automatic run_req(input bit w, input bit rd, input bit wr,
                           input logic [63:0] a, input logic [63:0] d,
                           output bit got_err, output logic [63:0] got_val,
                           output int done_at, output int busy_n, output int ndone);
        @(negedge clk);
        drive(w, rd, wr, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, a, d);
        done_at = 0; busy_n = 0; ndone = 0; got_err = 1'b0; got_val = '0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            if (s_busy(w)) busy_n++;
            if (s_done(w)) begin
                ndone++;
                if (done_at == 0) begin
                    done_at = i;
                    got_err = s_err(w);
                    got_val = s_val(w);
                end
            end
            if (done_at != 0 && i > done_at) break;
        end
    endtask

    task automatic check_req(input string nm, input bit w, input bit rd, input bit wr,
                             input logic [63:0] a, input logic [63:0] d,
                             input bit exp_err, input logic [63:0] exp_val);
        bit ge; logic [63:0] gv; int da, bn, nd, lat;
        lat = w ? 1 : 2;
        run_req(w, rd, wr, a, d, ge, gv, da, bn, nd);
        chk({nm, " done_cycle"}, 64'(da), 64'(lat + 1));
        chk({nm, " busy_cycles"}, 64'(bn), 64'(lat + 1));
        chk({nm, " done_pulses"}, 64'(nd), 64'd1);
        chk({nm, " dmem_error"}, 64'(ge), 64'(exp_err));
        chk({nm, " valM"}, gv, exp_val);
    endtask

    initial begin
        bit e;
        bit ge; logic [63:0] gv; int da, bn, nd;
        int n, bad;
        checks = 0; errors = 0;
        mval0 = '0; mval1 = '0;
        for (int i = 0; i < 1024; i++) mdl0[i] = 8'h00;
        for (int i = 0; i < 64; i++)   mdl1[i] = 8'h00;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        reset0 = 1'b1; reset1 = 1'b1;

        vecs[0]  = '{1'b0, 1'b1, 64'h10,  64'h1122334455667788, 1'b0, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 64'h10,  64'h0, 1'b0, 64'h1122334455667788};
        vecs[2]  = '{1'b1, 1'b0, 64'h13,  64'h0, 1'b0, 64'h0000001122334455};
        vecs[3]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1, 64'h0000001122334455};
        vecs[4]  = '{1'b1, 1'b0, 64'd1017, 64'h0, 1'b1, 64'h0000001122334455};
        vecs[5]  = '{1'b1, 1'b1, 64'h0,   64'hDEADBEEFDEADBEEF, 1'b1, 64'h0000001122334455};
        vecs[6]  = '{1'b1, 1'b0, 64'h0,   64'h0, 1'b0, 64'h0};
        vecs[7]  = '{1'b0, 1'b1, 64'h20,  64'hA5A5A5A55A5A5A5A, 1'b0, 64'h0};
        vecs[8]  = '{1'b0, 1'b1, 64'd1016, 64'hCAFEF00D12345678, 1'b0, 64'h0};
        vecs[9]  = '{1'b1, 1'b0, 64'd1016, 64'h0, 1'b0, 64'hCAFEF00D12345678};
        vecs[10] = '{1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 64'hCAFEF00D12345678};
        vecs[11] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'hCAFEF00D12345678};
        vecs[12] = '{1'b1, 1'b0, 64'h1B,  64'h0, 1'b0, 64'h5A5A5A0000000000};

        repeat (2) @(negedge clk);
        chk("reset valM", valm0, 64'h0);
        chk("reset mem_done", 64'(done0), 64'h0);
        chk("reset dmem_error", 64'(err0), 64'h0);
        chk("reset busy", 64'(busy0), 64'h0);
        chk("reset1 busy", 64'(busy1), 64'h0);
        chk("reset1 valM", valm1, 64'h0);
        reset0 = 1'b0; reset1 = 1'b0;

        // Bring memory contents to a known zero state through the normal port.
        for (int q = 0; q < 128; q++) run_req(1'b0, 1'b0, 1'b1, 64'(q * 8), 64'h0, ge, gv, da, bn, nd);
        for (int q = 0; q < 8; q++)   run_req(1'b1, 1'b0, 1'b1, 64'(q * 8), 64'h0, ge, gv, da, bn, nd);

        for (int v = 0; v < 13; v++) begin
            check_req($sformatf("vec%0d", v), 1'b0, vecs[v].rd, vecs[v].wr,
                      vecs[v].a, vecs[v].d, vecs[v].ee, vecs[v].ev);
            model_req(1'b0, vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, e);
        end

        // Second request while busy must be dropped.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 64'h40, 64'h0102030405060708);
        @(posedge clk);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) drive(1'b0, 1'b0, 1'b1, 64'h48, 64'hFFFFFFFFFFFFFFFF);
            if (i == 2) drive(1'b0, 1'b0, 1'b0, '0, '0);
            n += int'(done0);
        end
        chk("busy drop done_pulses", 64'(n), 64'd1);
        model_req(1'b0, 1'b0, 1'b1, 64'h40, 64'h0102030405060708, e);
        model_req(1'b0, 1'b1, 1'b0, 64'h48, 64'h0, e);
        check_req("dropped addr", 1'b0, 1'b1, 1'b0, 64'h48, 64'h0, e, mval0);
        model_req(1'b0, 1'b1, 1'b0, 64'h40, 64'h0, e);
        check_req("kept addr", 1'b0, 1'b1, 1'b0, 64'h40, 64'h0, e, mval0);

        // Reset during WAIT aborts the write.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 64'h20, 64'h1111111111111111);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("pre-reset busy", 64'(busy0), 64'd1);
        reset0 = 1'b1;
        #1;
        chk("abort valM", valm0, 64'h0);
        chk("abort mem_done", 64'(done0), 64'h0);
        chk("abort dmem_error", 64'(err0), 64'h0);
        chk("abort busy", 64'(busy0), 64'h0);
        @(negedge clk);
        reset0 = 1'b0;
        mval0 = '0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n += int'(done0);
        end
        chk("abort no done", 64'(n), 64'd0);
        model_req(1'b0, 1'b1, 1'b0, 64'h20, 64'h0, e);
        check_req("abort read 0x20", 1'b0, 1'b1, 1'b0, 64'h20, 64'h0, e, mval0);

        // LATENCY=1 with the enable held: one acceptance every 2 cycles.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 64'd8, 64'h0F0E0D0C0B0A0908);
        @(posedge clk);
        n = 0; bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done1 !== ((i % 2) == 0)) bad++;
            if (busy1 !== 1'b1) bad++;
            n += int'(done1);
            if (i == 8) drive(1'b1, 1'b0, 1'b0, '0, '0);
        end
        chk("held done_pulses", 64'(n), 64'd4);
        chk("held pattern_errors", 64'(bad), 64'd0);
        @(negedge clk);
        chk("held busy fall", 64'(busy1), 64'd0);
        model_req(1'b1, 1'b0, 1'b1, 64'd8, 64'h0F0E0D0C0B0A0908, e);
        model_req(1'b1, 1'b1, 1'b0, 64'd8, 64'h0, e);
        check_req("lat1 read 8", 1'b1, 1'b1, 1'b0, 64'd8, 64'h0, e, mval1);
        model_req(1'b1, 1'b1, 1'b0, 64'd57, 64'h0, e);
        check_req("lat1 read 57", 1'b1, 1'b1, 1'b0, 64'd57, 64'h0, e, mval1);

        // Randomized traffic against the reference model, both instances.
        for (int t = 0; t < 140; t++) begin
            bit w, rd, wr;
            int unsigned msz, r, op;
            logic [63:0] a, d;
            w   = (t >= 100);
            msz = w ? 64 : 1024;
            r   = $urandom_range(0, 9);
            if (r == 0)      a = {32'hFFFF_FFFF, $urandom()};
            else if (r == 1) a = 64'($urandom_range(msz - 12, msz - 1));
            else             a = 64'($urandom_range(0, msz - 8));
            op = $urandom_range(0, 9);
            rd = (op <= 4);
            wr = (op == 0) || (op >= 5);
            d  = {$urandom(), $urandom()};
            model_req(w, rd, wr, a, d, e);
            check_req($sformatf("rand%0d", t), w, rd, wr, a, d, e, w ? mval1 : mval0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
